// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its matching transmitter.
//   DATA_BITS    - default payload bits per frame
//   CLKS_PER_BIT - default clk cycles per serial bit
//   uart_state_e - frame-level FSM states
package uart_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
//   clk        - system clock
//   hard_rst   - synchronous active-high reset; both flops go to 1 (line idle)
//   rx_async_i - raw pad input
//   rx_sync_o  - synchronised line, two edges behind rx_async_i
module uart_rx_sync (
  input  logic clk,
  input  logic hard_rst,
  input  logic rx_async_i,
  output logic rx_sync_o
);

  logic meta_q;
  logic sync_q;

  // Resolve metastability over two stages; reset to the idle level.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_async_i;
      sync_q <= meta_q;
    end
  end

  assign rx_sync_o = sync_q;

endmodule

// File: rtl/uart_rx_fsmd.sv
// UART receiver: synchronises rx_in, detects the start bit, samples every bit
// at its midpoint and presents each word with a one-cycle valid strobe.
//   clk        - system clock, rising edge
//   hard_rst   - synchronous active-high reset
//   rx_in      - asynchronous serial line, idles high
//   rx_data    - last received word (LSB received first)
//   rx_valid   - one-cycle strobe; rx_data and the flags update with it
//   parity_err - parity mismatch on the last frame
//   frame_err  - stop bit sampled low on the last frame
//   rx_busy    - high whenever the FSM is not idle
module uart_rx_fsmd #(
  parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 hard_rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  import uart_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  // START waits half a bit so that later samples land mid-bit.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_sync_s;
  logic [CW-1:0]        cnt_last_s;
  logic                 expire_s;

  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;

  uart_rx_sync u_sync (
    .clk        (clk),
    .hard_rst   (hard_rst),
    .rx_async_i (rx_in),
    .rx_sync_o  (rx_sync_s)
  );

  // Baud-timer expiry for the current state.
  always_comb begin
    cnt_last_s = FULL_LAST;
    if (state_q == ST_START) begin
      cnt_last_s = HALF_LAST;
    end else begin
      cnt_last_s = FULL_LAST;
    end
    expire_s = (cnt_q == cnt_last_s);
  end

  // Frame FSM with datapath; the baud counter restarts on every transition,
  // including the DATA->DATA step between bits.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      bit_cnt_q    <= {BW{1'b0}};
      shift_q      <= {DATA_BITS{1'b0}};
      par_bit_q    <= 1'b0;
      rx_data_q    <= {DATA_BITS{1'b0}};
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= {CW{1'b0}};
          if (!rx_sync_s) begin
            state_q   <= ST_START;
            rx_busy_q <= 1'b1;
          end
        end

        ST_START: begin
          if (expire_s) begin
            cnt_q <= {CW{1'b0}};
            if (!rx_sync_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= {BW{1'b0}};
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (expire_s) begin
            cnt_q   <= {CW{1'b0}};
            shift_q <= {rx_sync_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (expire_s) begin
            cnt_q     <= {CW{1'b0}};
            par_bit_q <= rx_sync_s;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (expire_s) begin
            cnt_q        <= {CW{1'b0}};
            rx_data_q    <= shift_q;
            parity_err_q <= PARITY_EN ? (^shift_q ^ par_bit_q ^ PARITY_ODD) : 1'b0;
            frame_err_q  <= ~rx_sync_s;
            rx_valid_q   <= 1'b1;
            if (rx_sync_s) begin
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          // Hold off until the line recovers so a stuck-low line cannot retrigger.
          cnt_q <= {CW{1'b0}};
          if (rx_sync_s) begin
            state_q   <= ST_IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= {CW{1'b0}};
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: doc/uart_rx_fsmd.md
Name: uart_rx_fsmd

Overview:
- UART receiver, the counterpart of the team's UART transmitter FSMD; the two are intended to be looped back in test.
- Synchronises the asynchronous serial line, detects start bits, and samples each bit at its midpoint using a clock-count baud timer.
- Shifts data in LSB first and presents each received word with a one-cycle valid strobe plus parity and framing error flags.
- Sits between the pad and the system-side consumer; there is no back-pressure, so the consumer must take data on rx_valid.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9).
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and ≥4.
- PARITY_EN, 0, 1 = a parity bit follows the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, rising edge.
- hard_rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  one-cycle strobe; rx_data and the error flags are updated on this cycle.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit sampled low on the last frame.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On a clk edge with hard_rst=1, all state is cleared: FSM → IDLE, synchroniser flops → 1, counters → 0, shift register → 0.
  - Outputs after reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Reset mid-frame aborts the frame and produces no rx_valid.
- Synchroniser: two flops; rx_sync is the second flop's output. Latency from rx_in to rx_sync is 2 edges.
- Baud counter (cnt):
  - Width clog2(CLKS_PER_BIT).
  - Cleared on every state transition; increments every cycle otherwise.
  - A state "expires" on the edge where cnt == LIMIT-1.
  - LIMIT is CLKS_PER_BIT/2 in START and CLKS_PER_BIT in all other timed states.
- Bit counter: counts 0..DATA_BITS-1; cleared on entry to DATA.
- States:
  - IDLE: on an edge where rx_sync==0 → START.
  - START: on expiry, if rx_sync==0 → DATA, else → IDLE (glitch rejected; no strobe, no flags change).
  - DATA: on each expiry, shift rx_sync into the MSB and shift right, so the first bit ends at bit 0. After the bit-count reaches DATA_BITS-1 → PARITY if PARITY_EN, else → STOP.
  - PARITY: on expiry, capture the parity bit → STOP.
  - STOP: on expiry, sample the stop bit, then:
    - rx_data ← shift register.
    - parity_err ← (XOR of data ^ parity bit ^ PARITY_ODD) when PARITY_EN, else 0.
    - frame_err ← ~rx_sync.
    - rx_valid=1 for the following cycle only.
    - Next state: IDLE if rx_sync==1, else → BREAK.
  - BREAK: wait until rx_sync==1 → IDLE. This prevents a held-low line from retriggering.
- Timing:
  - If rx_in falls before edge E0, IDLE sees rx_sync low at E2.
  - START expires at E2+CLKS_PER_BIT/2.
  - Data bit i is sampled at E2+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop is sampled at E2+CLKS_PER_BIT/2+(DATA_BITS+PARITY_EN+1)·CLKS_PER_BIT; rx_valid is high for the cycle after that edge.
  - Defaults: stop sampled at E154, rx_valid high in cycle 154→155.
- rx_data, parity_err and frame_err hold their values until the next rx_valid. All three are registered outputs.
- rx_valid is asserted even on a framing or parity error; the consumer decides whether to discard.
- Back-to-back frames: because STOP returns to IDLE at mid-stop-bit, a start edge arriving half a bit later is detected with no lost cycles.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and the shared UART parameter defaults DATA_BITS and CLKS_PER_BIT, common with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchroniser with synchronous reset-to-1. The baud and bit counters stay inline.

Test Plan:
- Defaults; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_in falling before E0 → rx_valid high only in cycle 154→155, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy low after.
- PARITY_EN=1, PARITY_ODD=0; send 0x3C with correct parity 0 → parity_err=0. Resend with parity bit 1 → rx_valid pulses, rx_data=0x3C, parity_err=1.
- Send 0x55 with stop bit 0, then hold rx_in low for 40 cycles → frame_err=1 and rx_valid pulse; FSM stays in BREAK (rx_busy=1) with no further strobes until rx_in goes high, then IDLE.
- Low glitch of 3 clk cycles on an idle line → returns to IDLE at START expiry; no rx_valid; rx_data, parity_err and frame_err unchanged.
- Two frames back to back, 0xFF then 0x00, with no idle gap → two rx_valid pulses exactly 10·CLKS_PER_BIT=160 cycles apart, with correct data each time.
- Assert hard_rst for 1 cycle mid-DATA of a 0x81 frame → all outputs 0 the next cycle; no rx_valid for the aborted frame. A following clean frame 0x42 is received correctly.
